ibwt_decoder: RTL and testbench
===============================

IBWT_DECODER -- requirements
Module: ibwt_decoder

Interface
REQ-001 SHALL have parameter STRING_LEN, default 8, giving the symbol count per block (2..128).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request; sampled only in IDLE.
REQ-005 SHALL have port bwt_in  input  8 x STRING_LEN (unpacked)  last column L of sorted rotation matrix.
REQ-006 SHALL have port primary_idx  input  8  row of sorted matrix equal to the original string.
REQ-007 SHALL have port string_out  output  8 x STRING_LEN (unpacked)  reconstructed string, index 0 = first symbol.
REQ-008 SHALL have port busy  output  1  high from the cycle after start acceptance until done.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port err  output  1  valid with done; primary_idx out of range.

Function
REQ-011 SHALL implement states IDLE, LOAD, BUILD_LF, WALK, FINISH.
REQ-012 SHALL, in IDLE with start=1, go to LOAD; bwt_in and primary_idx SHALL be registered internally, and later input changes SHALL have no effect.
REQ-013 SHALL, in LOAD, clear the position counter i to 0 and go to BUILD_LF; if registered primary_idx >= STRING_LEN, SHALL go directly to FINISH with err=1.
REQ-014 SHALL, in BUILD_LF, compute one entry per cycle: LF[i] = less(L[i]) + rank(i), where less(c) = #{j : L[j] < c} and rank(i) = #{j < i : L[j] == L[i]}, all unsigned 8-bit compares.
REQ-015 SHALL leave BUILD_LF after i = STRING_LEN-1 (exactly STRING_LEN cycles), loading p = primary_idx and k = STRING_LEN-1.
REQ-016 SHALL, in WALK, each cycle write string_out[k] = L[p], then set p = LF[p] and k = k-1; SHALL go to FINISH after the k=0 write (exactly STRING_LEN cycles).
REQ-017 SHALL, in FINISH, pulse done for one cycle, drive err, drop busy, and return to IDLE.
REQ-018 SHALL assert done exactly 2*STRING_LEN+2 cycles after the start-sampling edge in the valid case, and exactly 2 cycles after it when err.
REQ-019 SHALL ignore start while not in IDLE, and SHALL ignore start coinciding with the FINISH cycle.
REQ-020 SHALL hold string_out stable from done until the next WALK write; on err, string_out SHALL be unchanged.
REQ-021 SHALL size counters to $clog2(STRING_LEN)+1 bits; less+rank SHALL never exceed STRING_LEN-1 and needs no saturation.
REQ-022 SHALL decode degenerate inputs (all symbols equal, symbol 8'h00 or 8'hFF) without special-casing.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, enter IDLE and clear busy, done, err, string_out (all 8'h00), LF table, i, k, p.
REQ-024 SHALL abort any operation on mid-operation reset with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-025 SHALL place the state enum, symbol width (8) and index-width function in shared package bwt_pkg, reused by the sort/bucket blocks.
REQ-026 SHALL instantiate a single combinational sub-module lf_calc (inputs L array and index i, output LF value), used once per cycle in BUILD_LF.

Verification
REQ-027 SHALL cover (STRING_LEN=4): bwt_in="caab", primary_idx=2, start -> done at cycle 10, string_out="bcaa", err=0.
REQ-028 SHALL cover (STRING_LEN=8): bwt_in all 8'h61, primary_idx=0 -> string_out all 8'h61, done at cycle 18.
REQ-029 SHALL cover: primary_idx=8 with STRING_LEN=8 -> done+err at cycle 2; string_out unchanged from prior value.
REQ-030 SHALL cover: rst asserted in WALK cycle 3 -> no done, all outputs zero; a new start then decodes correctly.
REQ-031 SHALL cover: start re-pulsed during BUILD_LF, and bwt_in changed mid-run -> ignored; single done; result matches first inputs.
REQ-032 SHALL cover: random 8-symbol strings encoded by the team's suffix-sort model -> round-trip string_out equals the original across 1000 runs.

Source files
------------

// File: rtl/bwt_pkg.sv
// Shared definitions for the BWT decode/sort blocks: symbol width,
// controller state encoding and index-width helpers.
package bwt_pkg;

    localparam int SYM_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_BUILD_LF = 3'd2,
        ST_WALK     = 3'd3,
        ST_FINISH   = 3'd4
    } state_e;

    // Counter width: one spare bit above the address width so that a
    // count equal to the block length is representable.
    function automatic int idx_width(input int n);
        return $clog2(n) + 1;
    endfunction

    // Address width needed to select one of n table entries.
    function automatic int addr_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/ibwt_decoder_lf_calc.sv
// Combinational LF-mapping for one position of the last column:
// LF[i] = (#symbols smaller than L[i]) + (#equal symbols before i).
module lf_calc
    import bwt_pkg::*;
#(
    parameter int  STRING_LEN = 8,
    localparam int IW         = idx_width(STRING_LEN),
    localparam int AW         = addr_width(STRING_LEN)
) (
    input  logic [SYM_W-1:0] l [STRING_LEN],
    input  logic [IW-1:0]    i,
    output logic [AW-1:0]    lf
);

    logic [SYM_W-1:0] w_sym;
    logic [AW-1:0]    w_cnt;

    assign w_sym = l[i[AW-1:0]];

    // Sum of less() and rank(); the total is a row index and never
    // exceeds STRING_LEN-1, so the address-width accumulator cannot wrap.
    always_comb begin
        w_cnt = '0;
        for (int j = 0; j < STRING_LEN; j++) begin
            if (l[j] < w_sym) begin
                w_cnt = w_cnt + AW'(1);
            end else if ((j < int'(i)) && (l[j] == w_sym)) begin
                w_cnt = w_cnt + AW'(1);
            end else begin
                w_cnt = w_cnt;
            end
        end
    end

    assign lf = w_cnt;

endmodule

// File: rtl/ibwt_decoder.sv
// Inverse Burrows-Wheeler transform: captures the last column and the
// primary row, builds the LF table one entry per cycle, then walks the
// LF chain backwards writing the original string from its end.
module ibwt_decoder
    import bwt_pkg::*;
#(
    parameter int STRING_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SYM_W-1:0] bwt_in [STRING_LEN],
    input  logic [7:0]       primary_idx,
    output logic [SYM_W-1:0] string_out [STRING_LEN],
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int             IW       = idx_width(STRING_LEN);
    localparam int             AW       = addr_width(STRING_LEN);
    localparam logic [IW-1:0]  LAST_IDX = IW'(STRING_LEN - 1);
    localparam logic [7:0]     LEN_B    = 8'(STRING_LEN);

    state_e           r_state;
    logic [SYM_W-1:0] r_l   [STRING_LEN];
    logic [AW-1:0]    r_lf  [STRING_LEN];
    logic [SYM_W-1:0] r_out [STRING_LEN];
    logic [7:0]       r_pidx;
    logic [IW-1:0]    r_i;
    logic [IW-1:0]    r_k;
    logic [AW-1:0]    r_p;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [AW-1:0]    w_lf;

    lf_calc #(
        .STRING_LEN (STRING_LEN)
    ) u_lf_calc (
        .l  (r_l),
        .i  (r_i),
        .lf (w_lf)
    );

    // Decode controller: all state, tables and outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pidx  <= 8'h00;
            r_i     <= '0;
            r_k     <= '0;
            r_p     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int n = 0; n < STRING_LEN; n++) begin
                r_l[n]   <= 8'h00;
                r_lf[n]  <= '0;
                r_out[n] <= 8'h00;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // Inputs are frozen here; later changes are ignored.
                        r_l     <= bwt_in;
                        r_pidx  <= primary_idx;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_state <= ST_LOAD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    r_i <= '0;
                    if (r_pidx >= LEN_B) begin
                        // Out-of-range row: report without touching string_out.
                        r_err   <= 1'b1;
                        r_state <= ST_FINISH;
                    end else begin
                        r_state <= ST_BUILD_LF;
                    end
                end
                ST_BUILD_LF: begin
                    r_lf[r_i[AW-1:0]] <= w_lf;
                    if (r_i == LAST_IDX) begin
                        r_p     <= r_pidx[AW-1:0];
                        r_k     <= LAST_IDX;
                        r_state <= ST_WALK;
                    end else begin
                        r_i     <= r_i + IW'(1);
                        r_state <= ST_BUILD_LF;
                    end
                end
                ST_WALK: begin
                    // The walk yields symbols in reverse order, last first.
                    r_out[r_k[AW-1:0]] <= r_l[r_p];
                    r_p                <= r_lf[r_p];
                    r_k                <= r_k - IW'(1);
                    if (r_k == '0) begin
                        r_state <= ST_FINISH;
                    end else begin
                        r_state <= ST_WALK;
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign string_out = r_out;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_ibwt_decoder.sv
// Self-checking bench for ibwt_decoder: a STRING_LEN=4 instance for the
// small worked example and a STRING_LEN=8 instance driven through a
// scoreboard of expected results popped on each done pulse.
module tb_ibwt_decoder;

    localparam int N8 = 8;
    localparam int N4 = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start4;
    logic [7:0] bwt8 [N8];
    logic [7:0] bwt4 [N4];
    logic [7:0] pidx8, pidx4;
    logic [7:0] out8 [N8];
    logic [7:0] out4 [N4];
    logic       busy8, done8, err8;
    logic       busy4, done4, err4;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    logic [63:0] last_str8 = 64'h0;

    typedef struct {
        logic [63:0] str;
        logic        err;
        int          start_cyc;
        int          lat;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;

    // Free-running edge counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    ibwt_decoder #(.STRING_LEN(N8)) dut8 (
        .clk (clk), .rst (rst), .start (start8), .bwt_in (bwt8),
        .primary_idx (pidx8), .string_out (out8), .busy (busy8),
        .done (done8), .err (err8)
    );

    ibwt_decoder #(.STRING_LEN(N4)) dut4 (
        .clk (clk), .rst (rst), .start (start4), .bwt_in (bwt4),
        .primary_idx (pidx4), .string_out (out4), .busy (busy4),
        .done (done4), .err (err4)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack8(input logic [7:0] a [N8]);
        logic [63:0] v;
        v = 64'h0;
        for (int t = 0; t < N8; t++) v = {v[55:0], a[t]};
        return v;
    endfunction

    function automatic logic [63:0] pack4(input logic [7:0] a [N4]);
        logic [63:0] v;
        v = 64'h0;
        for (int t = 0; t < N4; t++) v = {v[55:0], a[t]};
        return v;
    endfunction

    // Forward BWT reference: sort all rotations, take the last column.
    task automatic bwt_encode(input logic [7:0] s [N8], output logic [7:0] l [N8], output logic [7:0] p);
        logic [63:0] rot [N8];
        int          ord [N8];
        int          tmp;
        p = 8'h00;
        for (int r = 0; r < N8; r++) begin
            rot[r] = 64'h0;
            for (int t = 0; t < N8; t++) rot[r] = {rot[r][55:0], s[(r + t) % N8]};
            ord[r] = r;
        end
        for (int a = 1; a < N8; a++) begin
            for (int b = a; b > 0; b--) begin
                if (rot[ord[b-1]] > rot[ord[b]]) begin
                    tmp = ord[b-1]; ord[b-1] = ord[b]; ord[b] = tmp;
                end
            end
        end
        for (int j = 0; j < N8; j++) begin
            l[j] = s[(ord[j] + N8 - 1) % N8];
            if (ord[j] == 0) p = 8'(j);
        end
    endtask

    // Scoreboard monitor: every done must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            if (sb.size() == 0) begin
                check_val("spurious_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check_val("string", pack8(out8), e.str);
                check_val("err", 64'(err8), 64'(e.err));
                check_val("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
                check_val("busy_at_done", 64'(busy8), 64'd0);
            end
        end
    end

    task automatic start_decode8(input logic [7:0] l [N8], input logic [7:0] p,
                                 input logic [63:0] exp_str, input logic exp_err,
                                 output int s_cyc);
        exp_t e;
        @(negedge clk);
        bwt8   = l;
        pidx8  = p;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8      = 1'b0;
        s_cyc       = cyc;
        e.str       = exp_str;
        e.err       = exp_err;
        e.start_cyc = cyc;
        e.lat       = exp_err ? 2 : 2 * N8 + 2;
        sb.push_back(e);
        if (!exp_err) last_str8 = exp_str;
        check_val("busy_after_start", 64'(busy8), 64'd1);
    endtask

    task automatic wait_idle8();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            check_val("done_timeout", 64'd0, 64'd1);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        int g;
        g = 0;
        while (cyc < target && g < 1000) begin
            @(negedge clk);
            g++;
        end
    endtask

    initial begin
        logic [7:0] s [N8];
        logic [7:0] l [N8];
        logic [7:0] p;
        int         sc;
        int         g;

        rst    = 1'b1;
        start8 = 1'b0;
        start4 = 1'b0;
        pidx8  = 8'h00;
        pidx4  = 8'h00;
        for (int t = 0; t < N8; t++) bwt8[t] = 8'h00;
        for (int t = 0; t < N4; t++) bwt4[t] = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check_val("rst_out8", pack8(out8), 64'h0);
        check_val("rst_ctl8", {61'h0, busy8, done8, err8}, 64'h0);
        check_val("rst_out4", pack4(out4), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Worked example, STRING_LEN=4: L="caab", row 2 -> "bcaa"
        bwt4[0] = 8'h63; bwt4[1] = 8'h61; bwt4[2] = 8'h61; bwt4[3] = 8'h62;
        pidx4  = 8'd2;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        sc = cyc;
        check_val("busy4_after_start", 64'(busy4), 64'd1);
        g = 0;
        while (!done4 && g < 50) begin
            @(negedge clk);
            g++;
        end
        check_val("latency4", 64'(cyc - sc), 64'd10);
        check_val("string4", pack4(out4), 64'h62636161);
        check_val("err4", 64'(err4), 64'd0);

        // All symbols equal (8'h61), row 0
        for (int t = 0; t < N8; t++) s[t] = 8'h61;
        start_decode8(s, 8'd0, pack8(s), 1'b0, sc);
        wait_idle8();

        // Out-of-range rows: output must keep the previous string
        start_decode8(s, 8'd8, last_str8, 1'b1, sc);
        wait_idle8();
        start_decode8(s, 8'd255, last_str8, 1'b1, sc);
        wait_idle8();

        // Extreme symbol values, last valid row
        for (int t = 0; t < N8; t++) s[t] = 8'h00;
        start_decode8(s, 8'd7, pack8(s), 1'b0, sc);
        wait_idle8();
        for (int t = 0; t < N8; t++) s[t] = 8'hFF;
        start_decode8(s, 8'd7, pack8(s), 1'b0, sc);
        wait_idle8();

        // Reset in the middle of the walk: no done, everything cleared
        for (int t = 0; t < N8; t++) s[t] = 8'(8'h41 + t);
        bwt_encode(s, l, p);
        start_decode8(l, p, pack8(s), 1'b0, sc);
        wait_until(sc + N8 + 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        last_str8 = 64'h0;
        check_val("abort_out8", pack8(out8), 64'h0);
        check_val("abort_ctl8", {61'h0, busy8, done8, err8}, 64'h0);
        repeat (5) @(negedge clk);
        start_decode8(l, p, pack8(s), 1'b0, sc);
        wait_idle8();

        // Start re-pulsed in BUILD_LF with new inputs, and again in FINISH
        for (int t = 0; t < N8; t++) s[t] = 8'($urandom_range(97, 100));
        bwt_encode(s, l, p);
        start_decode8(l, p, pack8(s), 1'b0, sc);
        wait_until(sc + 3);
        start8 = 1'b1;
        for (int t = 0; t < N8; t++) bwt8[t] = 8'($urandom_range(0, 255));
        pidx8 = 8'($urandom_range(0, 7));
        @(negedge clk);
        start8 = 1'b0;
        wait_until(sc + 2 * N8 + 1);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_idle8();
        repeat (2) @(negedge clk);
        check_val("busy_after_ignored_start", 64'(busy8), 64'd0);

        // Random round trips through the reference encoder
        for (int run = 0; run < 1000; run++) begin
            for (int t = 0; t < N8; t++) begin
                s[t] = (run % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(97, 99));
            end
            bwt_encode(s, l, p);
            start_decode8(l, p, pack8(s), 1'b0, sc);
            wait_idle8();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
